// File: rtl/prom_dl.sv
// Synchronous PROM with one registered read port and a byte-stream download engine.
// Bytes are packed little-endian into words; length is checked and a byte sum is kept.
module prom_dl #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout,
    input  logic          dl_en,
    input  logic          dl_wr,
    input  logic [7:0]    dl_data,
    output logic          dl_done,
    output logic          dl_err,
    output logic [7:0]    dl_sum
);

    localparam int unsigned Depth   = 1 << AW;
    localparam int unsigned Bpw     = (DW <= 8) ? 1 : 2;
    localparam logic [AW:0] PtrFull = (AW + 1)'(Depth);
    localparam logic [AW:0] PtrLast = (AW + 1)'(Depth - 1);

    typedef enum logic {StIdle, StLoad} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic          r_en_prev;
    logic [AW:0]   r_ptr;
    logic          r_phase;
    logic [7:0]    r_low;
    logic          r_done;
    logic          r_err;
    logic [7:0]    r_sum;
    logic [DW-1:0] r_dout;
    logic [DW-1:0] r_mem [Depth];

    logic          w_start;
    logic          w_byte;
    logic          w_full;
    logic          w_we;
    logic [15:0]   w_word;
    logic          w_unused;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            StIdle: begin
                if (dl_en && !r_en_prev) begin
                    w_state_next = StLoad;
                    w_start      = 1'b1;
                end
            end
            StLoad: begin
                if (!dl_en) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_byte = (r_state == StLoad) && dl_en && dl_wr;
    assign w_full = (r_ptr == PtrFull);
    // A word is complete on every byte for narrow words, on the high byte for wide ones.
    assign w_we   = w_byte && !w_full && ((Bpw == 1) || r_phase);
    assign w_word = (Bpw == 1) ? {8'h00, dl_data} : {dl_data, r_low};
    assign w_unused = ^w_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_en_prev <= 1'b0;
            r_ptr     <= '0;
            r_phase   <= 1'b0;
            r_low     <= 8'h00;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sum     <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_en_prev <= dl_en;
            if (w_start) begin
                r_ptr   <= '0;
                r_phase <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_sum   <= 8'h00;
            end else if (r_state == StLoad) begin
                if (!dl_en) begin
                    // Window closed: short file is an error, a dangling low byte is dropped.
                    if (!w_full) begin
                        r_err <= 1'b1;
                    end
                    r_phase <= 1'b0;
                end else if (dl_wr) begin
                    r_sum <= r_sum + dl_data;
                    if (w_full) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b0;
                    end else if (w_we) begin
                        r_ptr   <= r_ptr + 1'b1;
                        r_phase <= 1'b0;
                        if (r_ptr == PtrLast) begin
                            r_done <= 1'b1;
                        end
                    end else begin
                        r_low   <= dl_data;
                        r_phase <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_ptr[AW-1:0]] <= w_word[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
        end else if (dl_en) begin
            r_dout <= '0;
        end else if (cs) begin
            r_dout <= r_mem[addr];
        end
    end

    assign dout    = r_dout;
    assign dl_done = r_done;
    assign dl_err  = r_err;
    assign dl_sum  = r_sum;

endmodule
